// File: rtl/fpga_message_framer.sv
`default_nettype none
// ============================================================================
// Module   : fpga_message_framer
// Purpose  : Buffers action and heartbeat message strobes, gives action
//            messages priority, and sends each one as a 7-word checksummed
//            16-bit frame on a valid/ready stream:
//            SYNC, {type,seq}, payload[63:48..15:0], checksum.
// Options  : define FPGA_MSG_SEQ_NUM_EN to put an 8-bit frame sequence number
//            in W1[7:0]. Without it, that byte is always zero.
// Revision : 1.0 - initial release
// ============================================================================
module fpga_message_framer #(
  parameter int unsigned MSG_FIFO_DEPTH = 4,
  parameter logic [15:0] SYNC_WORD      = 16'h55AA,
  parameter logic [7:0]  TYPE_ACTION    = 8'h01,
  parameter logic [7:0]  TYPE_HEARTBEAT = 8'h02
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        fpga_message_up_i,
  input  logic [63:0] fpga_message_up_data_i,
  input  logic        heartbeat_en_i,
  input  logic [63:0] heartbeat_data_i,
  output logic        tx_valid_o,
  output logic [15:0] tx_data_o,
  output logic        tx_last_o,
  input  logic        tx_ready_i,
  output logic        msg_drop_o,
  output logic [15:0] msg_drop_cnt_o,
  output logic [15:0] hb_overwrite_cnt_o
);

  localparam int unsigned    PTR_W   = (MSG_FIFO_DEPTH > 1) ? $clog2(MSG_FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(MSG_FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_TYPE = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4
  } state_t;

  // Action-message FIFO
  logic [63:0]      mem_q [MSG_FIFO_DEPTH];
  logic [63:0]      mem_d [MSG_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   fifo_cnt_q, fifo_cnt_d;
  logic             fifo_empty, fifo_full, act_push, act_pop, act_drop;

  // Heartbeat holding register
  logic        hb_pend_q, hb_pend_d, hb_take;
  logic [63:0] hb_data_q, hb_data_d;

  // Status counters
  logic        msg_drop_q, msg_drop_d;
  logic [15:0] drop_cnt_q, drop_cnt_d, hb_ow_cnt_q, hb_ow_cnt_d;

  // Frame engine
  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] csum_q, csum_d;
  logic [7:0]  frm_type_q, frm_type_d;
  logic [63:0] frm_payload_q, frm_payload_d;
  logic [7:0]  seq_w;
  logic        tx_hs;

  // Start a frame only from IDLE. Action messages win over a pending
  // heartbeat. A push into a full FIFO is still accepted when the same
  // cycle pops an entry.
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == CNT_MAX);
  assign act_pop    = (state_q == S_IDLE) && !fifo_empty;
  assign hb_take    = (state_q == S_IDLE) && fifo_empty && hb_pend_q;
  assign act_push   = fpga_message_up_i && (!fifo_full || act_pop);
  assign act_drop   = fpga_message_up_i && fifo_full && !act_pop;

  // tx_valid_o depends only on state, so it never depends on tx_ready_i.
  assign tx_valid_o         = (state_q != S_IDLE);
  assign tx_hs              = tx_valid_o && tx_ready_i;
  assign msg_drop_o         = msg_drop_q;
  assign msg_drop_cnt_o     = drop_cnt_q;
  assign hb_overwrite_cnt_o = hb_ow_cnt_q;

  // FIFO next state: write at the tail, read at the head, track occupancy.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (act_push) begin
      mem_d[wr_ptr_q] = fpga_message_up_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (act_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({act_push, act_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // Heartbeat: keep only the newest one. Count a strobe as an overwrite
  // only if the older heartbeat is lost unsent.
  always_comb begin
    hb_pend_d   = hb_pend_q;
    hb_data_d   = hb_data_q;
    hb_ow_cnt_d = hb_ow_cnt_q;
    if (heartbeat_en_i) begin
      hb_pend_d = 1'b1;
      hb_data_d = heartbeat_data_i;
      if (hb_pend_q && !hb_take && (hb_ow_cnt_q != 16'hFFFF)) begin
        hb_ow_cnt_d = hb_ow_cnt_q + 16'd1;
      end
    end else if (hb_take) begin
      hb_pend_d = 1'b0;
    end
  end

  // Drop reporting: pulse one cycle after the lost strobe; the count saturates.
  always_comb begin
    msg_drop_d = act_drop;
    drop_cnt_d = drop_cnt_q;
    if (act_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Frame FSM: choose the word on the bus, advance on handshake, and add
  // each issued W1..W5 word into the checksum.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    csum_d        = csum_q;
    frm_type_d    = frm_type_q;
    frm_payload_d = frm_payload_q;
    tx_data_o     = 16'h0000;
    tx_last_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        csum_d = 16'h0000;
        idx_d  = 2'd0;
        if (act_pop) begin
          frm_type_d    = TYPE_ACTION;
          frm_payload_d = mem_q[rd_ptr_q];
          state_d       = S_SYNC;
        end else if (hb_take) begin
          frm_type_d    = TYPE_HEARTBEAT;
          frm_payload_d = hb_data_q;
          state_d       = S_SYNC;
        end
      end
      S_SYNC: begin
        tx_data_o = SYNC_WORD;
        if (tx_hs) state_d = S_TYPE;
      end
      S_TYPE: begin
        tx_data_o = {frm_type_q, seq_w};
        if (tx_hs) begin
          csum_d  = csum_q + tx_data_o;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        case (idx_q)
          2'd0:    tx_data_o = frm_payload_q[63:48];
          2'd1:    tx_data_o = frm_payload_q[47:32];
          2'd2:    tx_data_o = frm_payload_q[31:16];
          default: tx_data_o = frm_payload_q[15:0];
        endcase
        if (tx_hs) begin
          csum_d = csum_q + tx_data_o;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        tx_data_o = csum_q;
        tx_last_o = 1'b1;
        if (tx_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef FPGA_MSG_SEQ_NUM_EN
  logic [7:0] seq_q, seq_d;

  // Shared sequence number: advance once per completed frame, wrapping at 8 bits.
  always_comb begin
    seq_d = seq_q;
    if (tx_hs && (state_q == S_CSUM)) seq_d = seq_q + 8'd1;
  end

  // Sequence number register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) seq_q <= 8'h00;
    else          seq_q <= seq_d;
  end

  assign seq_w = seq_q;
`else
  assign seq_w = 8'h00;
`endif

  // FIFO storage has no reset: it is only read once pointers mark it valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Control and status registers. Reset abandons any frame in progress.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      hb_pend_q     <= 1'b0;
      hb_data_q     <= 64'h0;
      msg_drop_q    <= 1'b0;
      drop_cnt_q    <= 16'h0000;
      hb_ow_cnt_q   <= 16'h0000;
      state_q       <= S_IDLE;
      idx_q         <= 2'd0;
      csum_q        <= 16'h0000;
      frm_type_q    <= 8'h00;
      frm_payload_q <= 64'h0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      hb_pend_q     <= hb_pend_d;
      hb_data_q     <= hb_data_d;
      msg_drop_q    <= msg_drop_d;
      drop_cnt_q    <= drop_cnt_d;
      hb_ow_cnt_q   <= hb_ow_cnt_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      csum_q        <= csum_d;
      frm_type_q    <= frm_type_d;
      frm_payload_q <= frm_payload_d;
    end
  end

endmodule
`default_nettype wire
